core_switch_ctrl: RTL and testbench

Sequencer that drives the A/B select line of the output switch between CPU A and CPU B. It monitors a heartbeat toggle from each CPU with per-core watchdog counters and fails over to the healthy standby core when the active core stops toggling. Every changeover passes through a timed guard window with output blanking. It sits beside the output switch: `ctr_io` feeds the switch select, and `out_blank` feeds the pad-safe logic.

---
 rtl/core_switch_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_core_switch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_switch_ctrl.sv
// core_switch_ctrl
//    Drives the A/B select of the output switch. Each CPU heartbeat is
//    synchronised and edge-detected, then feeds a per-core watchdog. The active
//    core fails over to a healthy standby through a blanked guard window.
//
//    Optional feature macro: CORE_SWITCH_MANUAL_EN (adds sw_req and manual
//    changeovers; without it changeovers are failover-only).
//
// Ports
//    clk        system clock
//    rst_n      asynchronous active-low reset
//    hb_a/hb_b  CPU heartbeats (asynchronous; any edge is a heartbeat)
//    sw_req     manual switch request, level (CORE_SWITCH_MANUAL_EN only)
//    ctr_io     switch select: 0 = CPU A, 1 = CPU B
//    out_blank  high during the guard window
//    a_ok/b_ok  core healthy flags
//    both_fail  registered: neither core healthy
//    sw_ack     registered 1-cycle pulse: changeover completed
//    sw_nack    registered 1-cycle pulse: request refused / changeover aborted
module core_switch_ctrl #(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned GUARD   = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic hb_a,
   input  logic hb_b,
`ifdef CORE_SWITCH_MANUAL_EN
   input  logic sw_req,
`endif
   output logic ctr_io,
   output logic out_blank,
   output logic a_ok,
   output logic b_ok,
   output logic both_fail,
   output logic sw_ack,
   output logic sw_nack
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   localparam int unsigned GD_W = $clog2(GUARD + 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
   localparam logic [GD_W-1:0] GD_LOAD = GD_W'(GUARD - 1);

   typedef enum logic [1:0] {
      ACT_A,
      GRD_B,
      ACT_B,
      GRD_A
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [GD_W-1:0] r_guard;
   logic [GD_W-1:0] w_guard_nxt;
   logic            w_ack_nxt;
   logic            w_nack_nxt;
   logic            r_ack;
   logic            r_nack;
   logic            r_both_fail;

   // [0],[1] = synchroniser stages, [2] = history flop
   logic [2:0]      r_sync_a;
   logic [2:0]      r_sync_b;
   logic            w_edge_a;
   logic            w_edge_b;
   logic [WD_W-1:0] r_wd_a;
   logic [WD_W-1:0] r_wd_b;
   logic            w_a_ok;
   logic            w_b_ok;
   logic            w_req_rise;

   // ---------------- heartbeat synchronisers and edge detect ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_a <= '0;
         r_sync_b <= '0;
      end else begin
         r_sync_a <= {r_sync_a[1:0], hb_a};
         r_sync_b <= {r_sync_b[1:0], hb_b};
      end
   end

   assign w_edge_a = r_sync_a[2] ^ r_sync_a[1];
   assign w_edge_b = r_sync_b[2] ^ r_sync_b[1];

   // ---------------- watchdogs (saturate at TIMEOUT) ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd_a <= '0;
         r_wd_b <= '0;
      end else begin
         if (w_edge_a)
            r_wd_a <= '0;
         else if (r_wd_a != WD_MAX)
            r_wd_a <= r_wd_a + 1'b1;

         if (w_edge_b)
            r_wd_b <= '0;
         else if (r_wd_b != WD_MAX)
            r_wd_b <= r_wd_b + 1'b1;
      end
   end

   assign w_a_ok = (r_wd_a != WD_MAX);
   assign w_b_ok = (r_wd_b != WD_MAX);

   // ---------------- manual request edge detect ----------------
`ifdef CORE_SWITCH_MANUAL_EN
   logic r_req_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_req_d <= 1'b0;
      else
         r_req_d <= sw_req;
   end

   assign w_req_rise = sw_req & ~r_req_d;
`else
   assign w_req_rise = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ACT_A;
         r_guard     <= '0;
         r_ack       <= 1'b0;
         r_nack      <= 1'b0;
         r_both_fail <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_guard     <= w_guard_nxt;
         r_ack       <= w_ack_nxt;
         r_nack      <= w_nack_nxt;
         r_both_fail <= ~w_a_ok & ~w_b_ok;
      end
   end

   // ---------------- FSM: next state ----------------
   // A timeout and a manual rise in the same cycle share one changeover.
   // Abort takes priority over guard completion.
   always_comb begin
      w_state_nxt = r_state;
      w_guard_nxt = r_guard;
      w_ack_nxt   = 1'b0;
      w_nack_nxt  = 1'b0;
      unique case (r_state)
         ACT_A: begin
            if ((!w_a_ok || w_req_rise) && w_b_ok) begin
               w_state_nxt = GRD_B;
               w_guard_nxt = GD_LOAD;
            end else if (w_req_rise) begin
               w_nack_nxt = 1'b1;
            end
         end
         GRD_B: begin
            if (!w_b_ok) begin
               w_state_nxt = ACT_A;
               w_nack_nxt  = 1'b1;
            end else if (r_guard == '0) begin
               w_state_nxt = ACT_B;
               w_ack_nxt   = 1'b1;
            end else begin
               w_guard_nxt = r_guard - 1'b1;
            end
         end
         ACT_B: begin
            if ((!w_b_ok || w_req_rise) && w_a_ok) begin
               w_state_nxt = GRD_A;
               w_guard_nxt = GD_LOAD;
            end else if (w_req_rise) begin
               w_nack_nxt = 1'b1;
            end
         end
         GRD_A: begin
            if (!w_a_ok) begin
               w_state_nxt = ACT_B;
               w_nack_nxt  = 1'b1;
            end else if (r_guard == '0) begin
               w_state_nxt = ACT_A;
               w_ack_nxt   = 1'b1;
            end else begin
               w_guard_nxt = r_guard - 1'b1;
            end
         end
         default: begin
            w_state_nxt = ACT_A;
         end
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Select and blanking decode straight from state so reset clears them at once.
   always_comb begin
      ctr_io    = (r_state == ACT_B) || (r_state == GRD_A);
      out_blank = (r_state == GRD_A) || (r_state == GRD_B);
   end

   assign a_ok      = w_a_ok;
   assign b_ok      = w_b_ok;
   assign both_fail = r_both_fail;
   assign sw_ack    = r_ack;
   assign sw_nack   = r_nack;

endmodule

// File: tb/tb_core_switch_ctrl.sv
module tb_core_switch_ctrl;

   localparam int T = 16;
   localparam int G = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic hb_a  = 1'b0;
   logic hb_b  = 1'b0;
`ifdef CORE_SWITCH_MANUAL_EN
   logic sw_req = 1'b0;
`endif
   logic ctr_io, out_blank, a_ok, b_ok, both_fail, sw_ack, sw_nack;

   core_switch_ctrl #(.TIMEOUT(T), .GUARD(G)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hb_a      (hb_a),
      .hb_b      (hb_b),
`ifdef CORE_SWITCH_MANUAL_EN
      .sw_req    (sw_req),
`endif
      .ctr_io    (ctr_io),
      .out_blank (out_blank),
      .a_ok      (a_ok),
      .b_ok      (b_ok),
      .both_fail (both_fail),
      .sw_ack    (sw_ack),
      .sw_nack   (sw_nack)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkn(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Health = cycles since the last observed heartbeat clear; a heartbeat
   // change seen at edge n clears the watchdog at edge n+2.
   // Switching = selected core plus remaining blanked cycles.
   int cyc = 0;
   int age_a = 0, age_b = 0;
   int qa[$], qb[$];
   bit seen_a = 0, seen_b = 0;
   int guard_left = 0;
   bit sel = 0, m_bf = 0, m_ack = 0, m_nack = 0, req_prev = 0;
   bit m_oka, m_okb, m_rise, m_req, m_cur, m_oth, m_clr;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         age_a = 0; age_b = 0; qa.delete(); qb.delete();
         seen_a = 0; seen_b = 0; guard_left = 0; sel = 0;
         m_bf = 0; m_ack = 0; m_nack = 0; req_prev = 0;
      end else begin
         cyc++;
         m_oka = (age_a < T);
         m_okb = (age_b < T);
`ifdef CORE_SWITCH_MANUAL_EN
         m_req = sw_req;
`else
         m_req = 1'b0;
`endif
         m_rise   = m_req && !req_prev;
         req_prev = m_req;
         m_bf   = !m_oka && !m_okb;
         m_ack  = 0;
         m_nack = 0;
         m_cur  = sel ? m_okb : m_oka;
         m_oth  = sel ? m_oka : m_okb;
         if (guard_left > 0) begin
            if (!m_oth) begin
               guard_left = 0; m_nack = 1;
            end else if (guard_left == 1) begin
               guard_left = 0; sel = !sel; m_ack = 1;
            end else begin
               guard_left--;
            end
         end else if ((!m_cur || m_rise) && m_oth) begin
            guard_left = G;
         end else if (m_rise) begin
            m_nack = 1;
         end
         m_clr = (qa.size() > 0 && qa[0] == cyc);
         if (m_clr) void'(qa.pop_front());
         age_a = m_clr ? 0 : ((age_a >= T) ? T : age_a + 1);
         if (hb_a != seen_a) begin qa.push_back(cyc + 2); seen_a = hb_a; end
         m_clr = (qb.size() > 0 && qb[0] == cyc);
         if (m_clr) void'(qb.pop_front());
         age_b = m_clr ? 0 : ((age_b >= T) ? T : age_b + 1);
         if (hb_b != seen_b) begin qb.push_back(cyc + 2); seen_b = hb_b; end
      end
   end

   // ---------------- per-cycle comparison ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("a_ok",      a_ok,      age_a < T);
         check("b_ok",      b_ok,      age_b < T);
         check("ctr_io",    ctr_io,    sel);
         check("out_blank", out_blank, guard_left > 0);
         check("both_fail", both_fail, m_bf);
         check("sw_ack",    sw_ack,    m_ack);
         check("sw_nack",   sw_nack,   m_nack);
      end
   end

   // ---------------- stimulus ----------------
   int tcnt = 0;
   bit en_a = 0, en_b = 0;

   task automatic step();
      @(negedge clk);
      tcnt++;
      if (en_a && (tcnt % 8 == 0)) hb_a = ~hb_a;
      if (en_b && (tcnt % 8 == 4)) hb_b = ~hb_b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   int cnt, blanks, acks, nacks;

   task automatic observe(input int n);
      repeat (n) begin
         step();
         if (out_blank) blanks++;
         if (sw_ack)    acks++;
         if (sw_nack)   nacks++;
      end
   endtask

   initial begin
      // Reset state
      step(); step(); step();
      chk_en = 1'b1;
      check("rst_ctr_io", ctr_io, 1'b0);
      check("rst_blank",  out_blank, 1'b0);
      check("rst_a_ok",   a_ok, 1'b1);
      check("rst_b_ok",   b_ok, 1'b1);
      check("rst_bf",     both_fail, 1'b0);

      // Reset idle with both heartbeats alive
      rst_n = 1'b1; en_a = 1; en_b = 1;
      blanks = 0; acks = 0; nacks = 0;
      observe(60);
      checkn("idle_blanks", blanks, 0);
      checkn("idle_acks",   acks, 0);
      check("idle_ctr_io",  ctr_io, 1'b0);

      // Failover A -> B
      en_a = 0; hb_a = ~hb_a;
      cnt = 0;
      while (a_ok && cnt < 60) begin step(); cnt++; end
      checkn("fo_a_ok_fall_cycles", cnt, 19);
      step();
      check("fo_blank_rise", out_blank, 1'b1);
      blanks = 1; acks = 0; nacks = 0;
      observe(30);
      checkn("fo_blanks", blanks, G);
      checkn("fo_acks",   acks, 1);
      checkn("fo_nacks",  nacks, 0);
      check("fo_ctr_io",  ctr_io, 1'b1);

      // Guard abort: b_ok falls during guard cycle 2
      do_reset(); en_a = 1; en_b = 1;
      repeat (20) step();
      en_a = 0; en_b = 0; hb_a = ~hb_a;
      cnt = 0;
      step(); cnt++; step(); cnt++;
      hb_b = ~hb_b;
      while (a_ok && cnt < 60) begin step(); cnt++; end
      checkn("ab_a_ok_fall_cycles", cnt, 19);
      blanks = 0; acks = 0; nacks = 0;
      observe(20);
      checkn("ab_blanks", blanks, 2);
      checkn("ab_nacks",  nacks, 1);
      checkn("ab_acks",   acks, 0);
      check("ab_ctr_io",  ctr_io, 1'b0);
      check("ab_both_fail", both_fail, 1'b1);

`ifdef CORE_SWITCH_MANUAL_EN
      // Manual switch held high: exactly one changeover
      do_reset(); en_a = 1; en_b = 1;
      repeat (20) step();
      sw_req = 1'b1;
      blanks = 0; acks = 0; nacks = 0;
      observe(20);
      sw_req = 1'b0;
      observe(5);
      checkn("man_acks",   acks, 1);
      checkn("man_blanks", blanks, G);
      checkn("man_nacks",  nacks, 0);
      check("man_ctr_io",  ctr_io, 1'b1);

      // Manual refused: standby B unhealthy
      do_reset(); en_a = 1; en_b = 0;
      repeat (25) step();
      check("ref_b_ok", b_ok, 1'b0);
      sw_req = 1'b1;
      blanks = 0; acks = 0; nacks = 0;
      observe(10);
      sw_req = 1'b0;
      checkn("ref_nacks",  nacks, 1);
      checkn("ref_blanks", blanks, 0);
      check("ref_ctr_io",  ctr_io, 1'b0);
`endif

      // Reset asserted during guard cycle 3
      do_reset(); en_a = 1; en_b = 1;
      repeat (20) step();
      en_a = 0; hb_a = ~hb_a;
      cnt = 0;
      while (!out_blank && cnt < 60) begin step(); cnt++; end
      check("rmg_in_guard", out_blank, 1'b1);
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      check("rmg_ctr_io", ctr_io, 1'b0);
      check("rmg_blank",  out_blank, 1'b0);
      check("rmg_a_ok",   a_ok, 1'b1);
      check("rmg_b_ok",   b_ok, 1'b1);
      check("rmg_bf",     both_fail, 1'b0);
      check("rmg_ack",    sw_ack, 1'b0);
      check("rmg_nack",   sw_nack, 1'b0);
      acks = 0; blanks = 0; nacks = 0;
      observe(3);
      rst_n = 1'b1; en_a = 1;
      observe(10);
      checkn("rmg_acks", acks, 0);
      check("rmg_ctr_io_after", ctr_io, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
